// File: rtl/imm_insert_pipe.sv
// Immediate inserter: packs a 32-bit immediate into the instruction fields for its
// imm_type, checks range and alignment, and emits the result through two valid/ready stages.
module imm_insert_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_in,
    input  logic [31:0]      imm_in,
    input  logic [2:0]       imm_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst_out,
    output logic             err_out,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_type_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic        s1_valid, s2_valid;
    logic [31:0] s1_inst, s2_inst;
    logic        s1_err, s2_err;
    logic        adv1, adv2, accept, fire;

    logic [31:0] packed_inst;
    logic [31:0] enc_inst;
    logic        enc_err;

    // Sign-extension checks: the bits above the field's sign bit must all match it.
    logic is_fit, b_fit, j_fit;
    assign is_fit = (&imm_in[31:11]) | ~(|imm_in[31:11]);
    assign b_fit  = (&imm_in[31:12]) | ~(|imm_in[31:12]);
    assign j_fit  = (&imm_in[31:20]) | ~(|imm_in[31:20]);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        packed_inst = inst_in;
        enc_err     = 1'b0;
        case (imm_type)
            IMM_I: begin
                packed_inst[31:20] = imm_in[11:0];
                enc_err            = !is_fit;
            end
            IMM_S: begin
                packed_inst[31:25] = imm_in[11:5];
                packed_inst[11:7]  = imm_in[4:0];
                enc_err            = !is_fit;
            end
            IMM_B: begin
                packed_inst[31]    = imm_in[12];
                packed_inst[30:25] = imm_in[10:5];
                packed_inst[11:8]  = imm_in[4:1];
                packed_inst[7]     = imm_in[11];
                enc_err            = !b_fit || imm_in[0];
            end
            IMM_J: begin
                packed_inst[31]    = imm_in[20];
                packed_inst[30:21] = imm_in[10:1];
                packed_inst[20]    = imm_in[11];
                packed_inst[19:12] = imm_in[19:12];
                enc_err            = !j_fit || imm_in[0];
            end
            IMM_U: begin
                packed_inst[31:12] = imm_in[19:0];
                enc_err            = |imm_in[31:20];
            end
            default: enc_err = 1'b1;
        endcase
        enc_inst = enc_err ? inst_in : packed_inst;
    end

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign accept    = in_valid && in_ready;
    assign fire      = s2_valid && out_ready;
    assign out_valid = s2_valid;
    assign inst_out  = s2_inst;
    assign err_out   = s2_err;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_inst  <= '0;
            s1_err   <= 1'b0;
            s2_valid <= 1'b0;
            s2_inst  <= '0;
            s2_err   <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_inst  <= enc_inst;
                s1_err   <= enc_err;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end
            // s2 holds its word untouched while the consumer stalls.
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_inst <= s1_inst;
                    s2_err  <= s1_err;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (fire) begin
            if (s2_err) begin
                if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
            end else begin
                if (enc_count != CNT_MAX) enc_count <= enc_count + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/imm_insert_pipe.md
Name: imm_insert_pipe

Overview:
- Encoder counterpart to the core's immediate extractor. Takes a 32-bit instruction template, a 32-bit immediate value and an imm_type, and writes the immediate into the type's instruction bit fields.
- Range and alignment are checked; the result is emitted through a 2-stage valid/ready pipeline.
- Used by the test-program generator and the boot-ROM patcher. Round-trip property: extracting the immediate from inst_out with the same imm_type returns imm_in whenever err_out=0.

Parameters:
- CNT_W, 16, width of saturating statistics counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage 1 can accept.
- inst_in  in  32  instruction template; non-immediate bits passed through.
- imm_in  in  32  immediate value (byte offset for B/J; raw upper 20 bits for U).
- imm_type  in  3  000 I, 001 S, 010 B, 011 J, 100 U, others illegal.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- inst_out  out  32  encoded instruction.
- err_out  out  1  immediate not representable, misaligned, or illegal type.
- enc_count  out  CNT_W  completed outputs with err_out=0.
- err_count  out  CNT_W  completed outputs with err_out=1.

Behaviour:
- Reset: s1_valid=0, s2_valid=0, out_valid=0, inst_out=0, err_out=0, enc_count=0, err_count=0. Reset mid-operation discards both stages.
- Field packing (inst_out bits replaced; all others taken from inst_in):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: [31:12]=imm[19:0].
- Error conditions:
  - I/S: error unless imm[31:11] all equal.
  - B: error unless imm[31:12] all equal and imm[0]=0.
  - J: error unless imm[31:20] all equal and imm[0]=0.
  - U: error unless imm[31:20]=0.
  - Types 101..111: error.
  - On any error, inst_out = inst_in unmodified and err_out=1.
- Stage 1 registers the packed word and the error flag. Stage 2 is the output register.
- Flow control:
  - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational from out_ready, no skid).
  - Accept occurs when in_valid & in_ready.
  - s1 loads on accept. s1_valid clears when it advances without a new accept.
  - s2 loads from s1 when s1_valid & adv2.
- Latency: accepted at edge N, out_valid=1 after edge N+1. Throughput is 1 per cycle with out_ready held high.
- Output stability: while out_valid & !out_ready, inst_out and err_out are held stable and no new input is lost.
- Counters: on out_valid & out_ready, increment enc_count or err_count. Both saturate at 2^CNT_W-1 and never wrap.
- in_valid is ignored while in_ready=0. Inputs are sampled only on accept.

Test Plan:
- I type: inst_in=0x00000013, imm_in=0xFFFFFFFF, type=000, out_ready=1 -> inst_out=0xFFF00013, err_out=0, out_valid exactly 2 edges after accept.
- B type: inst_in=0x00000063, imm_in=0x00000FFE -> inst_out=0x7E000FE3 (bit7=imm[11]=1). Same request with imm_in=0x00000FFF -> err_out=1, inst_out=0x00000063.
- J/U range: J with imm_in=0x00100000 -> err. U with imm_in=0x000ABCDE, inst_in=0x00000037 -> inst_out=0xABCDE037. U with imm_in=0x00100000 -> err. type=111 -> err.
- Backpressure: stream 4 back-to-back requests with out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full, outputs stay stable, order is preserved, none dropped or duplicated.
- Async reset asserted with both stages full -> out_valid=0 and both counters 0 immediately without a clock edge; first post-reset request completes normally.
- Randomized round-trip (≥10k requests): for every err_out=0 output, the immediate extractor applied to inst_out returns imm_in. Counters are checked against the scoreboard, and saturation is checked with CNT_W=4.
